// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU function codes
// and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_NOP   = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_MUL    = 3'd3,
    ST_MULFIN = 3'd4,
    ST_RESP   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu_seq_legal.sv
// Combinational function-code decode: flags codes the ALU understands
// and singles out the multi-cycle multiply.
module alu_seq_legal
  import alu_seq_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic       is_legal_o,
  output logic       is_mul_o
);

  // Classify the incoming function code; anything unlisted (including NOP) is illegal.
  always_comb begin
    is_legal_o = 1'b0;
    is_mul_o   = 1'b0;
    case (funct_i)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SRL, FN_MFHI, FN_MFLO: begin
        is_legal_o = 1'b1;
      end
      FN_MULTU: begin
        is_legal_o = 1'b1;
        is_mul_o   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue sequencer in front of a registered ALU. Accepts one operation at a
// time, drives registered operands/function to the ALU, holds MULTU for the
// multiplier latency and returns exactly one response per operation.
// Optional performance counters are built when ALU_SEQ_PERF_EN is defined.
module alu_issue_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_dataA,
  output logic [DATA_W-1:0] alu_dataB,
  output logic [5:0]        alu_signal,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_stall
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [5:0]        sig_q, sig_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              is_legal, is_mul;

  alu_seq_legal u_legal (
    .funct_i    (in_funct),
    .is_legal_o (is_legal),
    .is_mul_o   (is_mul)
  );

  assign in_ready   = (state_q == ST_IDLE) && !reset;
  assign out_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign alu_dataA  = a_q;
  assign alu_dataB  = b_q;
  assign alu_signal = sig_q;
  assign out_data   = data_q;
  assign out_err    = err_q;

  // Next-state logic: accept, walk the ALU pipeline or multiply hold, then respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sig_d   = sig_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d = in_a;
          b_d = in_b;
          if (!is_legal) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = ST_RESP;
          end else begin
            err_d = 1'b0;
            sig_d = in_funct;
            if (is_mul) begin
              cnt_d   = CNT_LOAD;
              state_d = ST_MUL;
            end else begin
              state_d = ST_ISSUE;
            end
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        data_d  = alu_result;
        sig_d   = FN_NOP;
        state_d = ST_RESP;
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          sig_d   = FN_NOP;
          state_d = ST_MULFIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MULFIN: begin
        data_d  = '0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        sig_d   = FN_NOP;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sig_q   <= FN_NOP;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sig_q   <= sig_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] ops_q, stall_q;

  // Count completed handshakes and cycles spent waiting on the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid && out_ready) begin
        ops_q <= ops_q + 32'd1;
      end
      if ((state_q == ST_MUL) || (state_q == ST_MULFIN)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`else
  assign perf_ops   = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer with a small registered ALU
// model behind it. Responses are checked by a scoreboard monitor; timing
// and boundary behaviour by directed checks. Define ALU_SEQ_PERF_EN to
// exercise the performance counters.
module tb_alu_issue_sequencer;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_funct = FN_NOP;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] alu_dataA, alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;
  logic [31:0] perf_ops, perf_stall;

  int   nCompared = 0;
  int   nMismatched = 0;
  exp_t sb[$];

  logic [31:0] aluHi, aluLo;

  alu_issue_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_dataA  (alu_dataA),
    .alu_dataB  (alu_dataB),
    .alu_signal (alu_signal),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .busy       (busy),
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
  );

  always #5 clk = ~clk;

  // Registered ALU stand-in: result one cycle after the function is driven,
  // Hi/Lo captured while MULTU is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result <= '0;
      aluHi      <= '0;
      aluLo      <= '0;
    end else begin
      case (alu_signal)
        FN_ADD:   alu_result <= alu_dataA + alu_dataB;
        FN_SUB:   alu_result <= alu_dataA - alu_dataB;
        FN_AND:   alu_result <= alu_dataA & alu_dataB;
        FN_OR:    alu_result <= alu_dataA | alu_dataB;
        FN_SLT:   alu_result <= {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
        FN_SRL:   alu_result <= alu_dataA >> alu_dataB[4:0];
        FN_MULTU: {aluHi, aluLo} <= {32'd0, alu_dataA} * {32'd0, alu_dataB};
        FN_MFHI:  alu_result <= aluHi;
        FN_MFLO:  alu_result <= aluLo;
        default:  alu_result <= alu_result;
      endcase
    end
  end

  // Monitor: every response handshake is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      nCompared++;
      if (sb.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL resp_unexpected: got data=0x%08h err=%0b, required no response", out_data, out_err);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_err !== e.err) begin
          nMismatched++;
          $display("[TB] FAIL resp: got data=0x%08h err=%0b, required data=0x%08h err=%0b",
                   out_data, out_err, e.data, e.err);
        end
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expData, input logic expErr, input bit expectResp);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_funct = f;
      in_a     = a;
      in_b     = b;
      if (expectResp) begin
        e.data = expData;
        e.err  = expErr;
        sb.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic waitOutValid();
    int guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    int n;
    int bad;

    // Reset behaviour, including in_ready forced low while reset is high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready_in_reset", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_alu_signal", 32'(alu_signal), 32'd63);
    checkOutput("rst_alu_dataA", alu_dataA, 32'd0);
    checkOutput("rst_alu_dataB", alu_dataB, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_perf_ops", perf_ops, 32'd0);
    checkOutput("rst_perf_stall", perf_stall, 32'd0);

    // ADD with latency checks.
    applyStimulus(FN_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
    checkOutput("add_alu_signal", 32'(alu_signal), 32'd32);
    checkOutput("add_alu_dataA", alu_dataA, 32'd5);
    checkOutput("add_valid_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("add_valid_c2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("add_valid_c3", 32'(out_valid), 32'd1);
    checkOutput("add_resp_signal_nop", 32'(alu_signal), 32'd63);
    waitDrain();

    // Other single-cycle operations.
    applyStimulus(FN_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b1);
    applyStimulus(FN_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b1);
    applyStimulus(FN_OR, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b1);
    applyStimulus(FN_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1);
    applyStimulus(FN_SRL, 32'h0000_0080, 32'd3, 32'h0000_0010, 1'b0, 1'b1);
    waitDrain();

    // MULTU 3*4: multiply held exactly MUL_CYCLES, then read Lo.
    applyStimulus(FN_MULTU, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
    n = 0;
    bad = 0;
    while (alu_signal == FN_MULTU && n < 100) begin
      n++;
      if (in_ready) bad++;
      @(posedge clk); #1;
    end
    checkOutput("mul_hold_cycles", 32'(n), 32'd32);
    checkOutput("mul_in_ready_low", 32'(bad), 32'd0);
    applyStimulus(FN_MFLO, 32'd0, 32'd0, 32'd12, 1'b0, 1'b1);
    waitDrain();

    // Product crossing into Hi.
    applyStimulus(FN_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1);
    applyStimulus(FN_MFHI, 32'd0, 32'd0, 32'd1, 1'b0, 1'b1);
    applyStimulus(FN_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    waitDrain();

    // Illegal function code.
    applyStimulus(6'h3F, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
    checkOutput("illegal_signal_c1", 32'(alu_signal), 32'd63);
    waitOutValid();
    checkOutput("illegal_valid", 32'(out_valid), 32'd1);
    checkOutput("illegal_signal_resp", 32'(alu_signal), 32'd63);
    waitDrain();

    // Backpressure: response held, next operation waits for the handshake.
    out_ready = 1'b0;
    applyStimulus(FN_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b1);
    waitOutValid();
    @(negedge clk);
    in_valid = 1'b1;
    in_funct = FN_ADD;
    in_a     = 32'd100;
    in_b     = 32'd1;
    sb.push_back('{data: 32'd101, err: 1'b0});
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== 32'd7 || in_ready) bad++;
    end
    checkOutput("bp_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_idle_after_hs", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_second_accepted", 32'(alu_signal), 32'd32);
    waitDrain();

    // Reset in the middle of a multiply: no response, then normal operation.
    applyStimulus(FN_MULTU, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midmul_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("midmul_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midmul_alu_signal", 32'(alu_signal), 32'd63);
    checkOutput("midmul_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(FN_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1'b1);
    waitDrain();

    // Performance counters from a clean reset: one MULTU plus two ADDs.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(FN_MULTU, 32'd2, 32'd2, 32'd0, 1'b0, 1'b1);
    applyStimulus(FN_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
    applyStimulus(FN_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b1);
    waitDrain();
    @(negedge clk);
`ifdef ALU_SEQ_PERF_EN
    checkOutput("perf_ops", perf_ops, 32'd3);
    checkOutput("perf_stall", perf_stall, 32'd33);
`else
    checkOutput("perf_ops", perf_ops, 32'd0);
    checkOutput("perf_stall", perf_stall, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_issue_sequencer.md
ALU_ISSUE_SEQUENCER -- requirements
Module: alu_issue_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 32: cycles the ALU's multiplier needs with MULTU held stable.
REQ-002 Parameter DATA_W, default 32: operand/result width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  sequencer accepts an operation this cycle (high only in IDLE).
REQ-007 in_funct  input  6  operation code (ADD, SUB, AND, OR, SLT, SRL, MULTU, MFHI, MFLO).
REQ-008 in_a, in_b  input  32 each  operands.
REQ-009 alu_dataA, alu_dataB  output  32 each  registered operands to the ALU.
REQ-010 alu_signal  output  6  registered function code to the ALU.
REQ-011 alu_result  input  32  registered ALU output.
REQ-012 out_valid  output  1  response available.
REQ-013 out_ready  input  1  downstream accepts the response.
REQ-014 out_data  output  32  result.
REQ-015 out_err  output  1  illegal funct flag.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 perf_ops, perf_stall  output  32 each  performance counters (see Configuration).

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, MUL, MULFIN, RESP.
REQ-019 IDLE: in_valid & in_ready is an accept; latch funct and operands and drive alu_* in the next cycle. Legal non-MULTU goes to ISSUE, MULTU to MUL, illegal to RESP with out_err=1 and out_data=0.
REQ-020 ISSUE -> WAIT -> RESP: alu_result is sampled at the end of WAIT; out_valid rises 3 cycles after the accept edge.
REQ-021 MUL: hold alu_signal=MULTU and the operands stable for exactly MUL_CYCLES cycles, counted by a down-counter loaded with MUL_CYCLES-1; at 0 go to MULFIN.
REQ-022 MULFIN: one cycle for the Hi/Lo latch; then RESP with out_data=0 and out_err=0.
REQ-023 RESP: hold out_valid and out_data stable until out_valid & out_ready, then go to IDLE; in_ready stays low that cycle.
REQ-024 Exactly one response per accepted operation; at most one operation in flight, so MFHI/MFLO after MULTU always read completed Hi/Lo.
REQ-025 In IDLE and RESP, alu_signal=FN_NOP and operands hold their last values.
REQ-026 in_valid while not in_ready is ignored; upstream holds it.

Reset
REQ-027 Reset forces IDLE, counter 0, out_valid=0, out_err=0, out_data=0, alu_dataA=alu_dataB=0, alu_signal=FN_NOP, busy=0, and perf counters 0.
REQ-028 Reset in any state, including mid-MUL, aborts the operation with no response; the same reset drives the ALU's own reset at top level.
REQ-029 in_ready is 0 in the cycle reset is asserted.

Configuration
REQ-030 With ALU_SEQ_PERF_EN defined: perf_ops increments on each response handshake, and perf_stall increments each cycle in MUL or MULFIN; both wrap at 2^32.
REQ-031 Without ALU_SEQ_PERF_EN: perf_ops and perf_stall are tied to 0 with no counter logic; the ports remain.

Structure
REQ-032 Package alu_seq_pkg holds the funct constants (FN_ADD=32, FN_SUB=34, FN_AND=36, FN_OR=37, FN_SLT=42, FN_SRL=2, FN_MULTU=25, FN_MFHI=16, FN_MFLO=18, FN_NOP=63) and the state enum.
REQ-033 One sub-module, alu_seq_legal, is combinational funct decode returning is_legal and is_mul.

Verification
REQ-034 ADD a=5 b=7, out_ready=1 -> alu_signal=32 one cycle after accept; out_valid 3 cycles after accept; out_data=12.
REQ-035 MULTU a=3 b=4, then MFLO -> alu_signal=25 for exactly 32 cycles; MULTU response out_data=0; MFLO response out_data=12; in_ready low throughout.
REQ-036 funct=6'h3F -> out_err=1, out_data=0; no alu_signal change from FN_NOP.
REQ-037 out_ready held low 10 cycles in RESP -> out_valid and out_data stable; no new accept until the handshake.
REQ-038 Reset at MUL cycle 10 -> next cycle IDLE, out_valid=0, alu_signal=63; a following ADD completes normally.
REQ-039 ALU_SEQ_PERF_EN defined; one MULTU plus two ADDs -> perf_ops=3, perf_stall=33; undefined -> both 0.
